// File: rtl/gate_selftest_ctrl.sv
// Built-in self-test sequencer for a 2-input gate: walks {A,B} through 00,01,10,11,
// holds each vector SETTLE_CYCLES cycles, and records per-vector mismatches against EXPECTED.
module gate_selftest_ctrl #(
  parameter logic [3:0]  EXPECTED      = 4'b1110,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       gate_out,
  output logic       A,
  output logic       B,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] vec_idx
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("gate_selftest_ctrl: SETTLE_CYCLES must be in 1..255");
  end

  localparam int unsigned    CW     = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]  RELOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    vec_d;
  logic [3:0]    mask_d;
  logic          busy_d, done_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state;
    cnt_d   = cnt;
    vec_d   = vec_idx;
    mask_d  = fail_mask;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = SETTLE;
          cnt_d   = RELOAD;
          vec_d   = 2'd0;
          mask_d  = 4'd0;
        end
      end
      SETTLE: begin
        if (cnt != '0) begin
          cnt_d = cnt - CW'(1);
        end else begin
          // Mask bits are sticky within a run; only a new start or rst clears them.
          if (gate_out != EXPECTED[vec_idx]) mask_d[vec_idx] = 1'b1;
          if (vec_idx == 2'd3) begin
            state_d = DONE;
          end else begin
            vec_d = vec_idx + 2'd1;
            cnt_d = RELOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SETTLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      vec_idx   <= 2'd0;
      fail_mask <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      vec_idx   <= vec_d;
      fail_mask <= mask_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Gate drives come straight from the registered vector index, so they change with vec_idx.
  assign A    = vec_idx[1];
  assign B    = vec_idx[0];
  assign pass = done && (fail_mask == 4'd0);

endmodule
